// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 block feeder and its word buffer.
package sha256_pkg;

   localparam logic [255:0] SHA256_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam int BLOCK_WORDS = 16;

   // Byte counter width; the 64-bit length field is this count times 8.
   localparam int LEN_W = 61;

   typedef enum logic [2:0] {FILL, ISSUE, WAIT, PAD, DONE} state_t;

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 message block buffer: indexed word writes, 0x80/zero padding from a byte
// offset, 64-bit length words, and a pad-only block load. Word 0 sits in block[511:480].
module sha256_block_buf
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [3:0]   wr_idx,
   input  logic [31:0]  wr_data,
   input  logic         close_en,
   input  logic [6:0]   nb,
   input  logic         len_en,
   input  logic         pad_en,
   input  logic         pad_mark,
   input  logic [63:0]  len_bits,
   output logic [511:0] block
);

   logic [31:0] mem [BLOCK_WORDS];
   logic [31:0] nxt [BLOCK_WORDS];

   always_comb begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
         nxt[i] = mem[i];
         if (pad_en) begin
            nxt[i] = '0;
         end else if (wr_en && !close_en && i == int'(wr_idx)) begin
            nxt[i] = wr_data;
         end else if (wr_en && close_en && i >= int'(wr_idx)) begin
            // Bytes below nb keep message data, byte nb is the 0x80 marker, the rest clear.
            for (int j = 0; j < 4; j++) begin
               if (4*i + j < int'(nb))
                  nxt[i][31-8*j -: 8] = wr_data[31-8*j -: 8];
               else if (4*i + j == int'(nb))
                  nxt[i][31-8*j -: 8] = 8'h80;
               else
                  nxt[i][31-8*j -: 8] = 8'h00;
            end
         end
      end
      if (pad_en && pad_mark)
         nxt[0] = 32'h8000_0000;
      if (pad_en || (wr_en && close_en && len_en)) begin
         nxt[14] = len_bits[63:32];
         nxt[15] = len_bits[31:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem <= '{default: '0};
      else        mem <= nxt;
   end

   for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_flat
      assign block[511-32*g -: 32] = mem[g];
   end

endmodule

// File: rtl/sha256_block_feeder.sv
// SHA-256 message feeder: packs a word stream into padded 512-bit blocks, drives the
// round engine one block at a time, folds each result into H and issues the digest.
module sha256_block_feeder
   import sha256_pkg::*;
#(
   parameter logic [255:0] IV = SHA256_IV
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  s_data,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         s_last,
   input  logic [1:0]   s_bytes,
   output logic [511:0] core_m,
   output logic [255:0] core_h,
   output logic         core_in_v,
   input  logic [255:0] core_h_out,
   input  logic         core_out_v,
   output logic [255:0] digest,
   output logic         digest_v,
   output logic         busy
);

   state_t           state, state_nxt;
   logic [3:0]       widx;
   logic [LEN_W-1:0] len, len_nxt;
   logic [255:0]     h;
   logic             final_blk, pad_pend, pad_mark;
   logic             take;
   logic [2:0]       nbytes;
   logic [6:0]       nb;

   // Words move on s_valid && s_ready; s_ready is FILL only and low while in reset.
   assign s_ready   = rst_n && (state == FILL);
   assign take      = s_valid && s_ready;
   assign nbytes    = (s_last && s_bytes != 2'd0) ? {1'b0, s_bytes} : 3'd4;
   assign nb        = {1'b0, widx, 2'b00} + {4'b0000, nbytes};
   assign len_nxt   = len + LEN_W'(nbytes);
   assign core_in_v = (state == ISSUE);
   assign digest_v  = (state == DONE);
   assign core_h    = h;
   assign busy      = (state != FILL) || (len != '0);

   sha256_block_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (take),
      .wr_idx   (widx),
      .wr_data  (s_data),
      .close_en (s_last),
      .nb       (nb),
      .len_en   (nb <= 7'd55),
      .pad_en   (state == PAD),
      .pad_mark (pad_mark),
      .len_bits ({(take ? len_nxt : len), 3'b000}),
      .block    (core_m)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:  if (take && (s_last || widx == 4'd15)) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (core_out_v) begin
               if (final_blk)     state_nxt = DONE;
               else if (pad_pend) state_nxt = PAD;
               else               state_nxt = FILL;
            end
         end
         PAD:   state_nxt = ISSUE;
         DONE:  state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         widx      <= '0;
         len       <= '0;
         h         <= IV;
         digest    <= '0;
         final_blk <= 1'b0;
         pad_pend  <= 1'b0;
         pad_mark  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (take) begin
                  widx <= widx + 4'd1;
                  len  <= len_nxt;
                  if (s_last) begin
                     final_blk <= (nb <= 7'd55);
                     pad_pend  <= (nb > 7'd55);
                     pad_mark  <= (nb == 7'd64);
                  end else begin
                     final_blk <= 1'b0;
                     pad_pend  <= 1'b0;
                  end
               end
            end
            WAIT: begin
               // Leaving WAIT on the first out_v makes any later pulse irrelevant.
               if (core_out_v) begin
                  h    <= core_h_out;
                  widx <= '0;
                  if (final_blk) digest <= core_h_out;
               end
            end
            PAD: begin
               final_blk <= 1'b1;
               pad_pend  <= 1'b0;
            end
            DONE: begin
               h    <= IV;
               len  <= '0;
               widx <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
